// File: rtl/mips_fetch_sequencer_pkg.sv
// Shared fetch-path parameters, the fetch state enum and the queue entry type.
package mips_fetch_sequencer_pkg;

    localparam int Instruction_Width          = 32;
    localparam int Instruction_Mem_Addr_Width = 6;
    // Not a power of two, so out-of-range redirect targets are representable.
    localparam int Instruction_Mem_Depth      = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [Instruction_Mem_Addr_Width-1:0] pc;
        logic [Instruction_Width-1:0]          instr;
    } fetch_entry_t;

    // Sequential word index, wrapping at the top of instruction memory.
    function automatic logic [Instruction_Mem_Addr_Width-1:0] next_pc(
        input logic [Instruction_Mem_Addr_Width-1:0] pc
    );
        if (pc == Instruction_Mem_Addr_Width'(Instruction_Mem_Depth - 1))
            return '0;
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/mips_fetch_sequencer_if.sv
// ROM bus, redirect request and decode handshake of the fetch sequencer.
interface mips_fetch_sequencer_if;
    import mips_fetch_sequencer_pkg::*;

    logic [Instruction_Mem_Addr_Width-1:0] rom_addr;
    logic [Instruction_Width-1:0]          rom_data;
    logic                                  redirect_valid;
    logic [Instruction_Mem_Addr_Width-1:0] redirect_addr;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [Instruction_Width-1:0]          out_instr;
    logic [Instruction_Mem_Addr_Width-1:0] out_pc;
    logic                                  fault;

    modport master (
        output rom_addr, out_valid, out_instr, out_pc, fault,
        input  rom_data, redirect_valid, redirect_addr, out_ready
    );

    modport slave (
        input  rom_addr, out_valid, out_instr, out_pc, fault,
        output rom_data, redirect_valid, redirect_addr, out_ready
    );

endinterface

// File: rtl/mips_fetch_queue.sv
// In-order {pc, instr} FIFO with flush; head is read straight from storage flops.
module mips_fetch_queue
    import mips_fetch_sequencer_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer/count bookkeeping; flush wins over push and pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop)
                rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    // Storage and pointers; storage clears so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/mips_fetch_sequencer.sv
// Fetch controller: owns fetch_pc, drives the ROM, queues words for decode, applies redirects.
module mips_fetch_sequencer
    import mips_fetch_sequencer_pkg::*;
#(
    parameter int Queue_Depth = 2,
    parameter int Reset_PC    = 0
) (
    input logic clk,
    input logic rst_n,
    input logic en,
    mips_fetch_sequencer_if.master bus
);

    localparam int         CNT_W  = $clog2(Queue_Depth + 1);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_HALT = 2'(HALT);

    logic [1:0]                            state_q, state_d;
    logic [Instruction_Mem_Addr_Width-1:0] fetch_pc_q, fetch_pc_d;
    logic                                  fault_q, fault_d;

    logic             redir, redir_oob, push, pop, out_valid;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head, din;

    assign out_valid = (count != '0);
    assign pop       = out_valid && bus.out_ready;
    // HALT ignores redirects entirely.
    assign redir     = bus.redirect_valid && (state_q != S_HALT);
    assign redir_oob = bus.redirect_addr >= Instruction_Mem_Addr_Width'(Instruction_Mem_Depth);
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push      = (state_q == S_RUN) && en && !redir &&
                       ((count < CNT_W'(Queue_Depth)) ||
                        ((count == CNT_W'(Queue_Depth)) && pop));
    assign din       = '{pc: fetch_pc_q, instr: bus.rom_data};

    mips_fetch_queue #(.DEPTH(Queue_Depth)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redir),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count)
    );

    // State, fetch_pc and fault updates; redirect outranks sequential fetch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        if (redir) begin
            if (redir_oob) begin
                fault_d = 1'b1;
                state_d = S_HALT;
            end else begin
                fetch_pc_d = bus.redirect_addr;
                if (state_q == S_RUN && !en)
                    state_d = S_IDLE;
            end
        end else begin
            if (push)
                fetch_pc_d = next_pc(fetch_pc_q);
            case (state_q)
                S_IDLE:  if (en)  state_d = S_RUN;
                S_RUN:   if (!en) state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Control flops; everything clears asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= Instruction_Mem_Addr_Width'(Reset_PC);
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.rom_addr  = fetch_pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Directed + random bench for the fetch sequencer against a queue-based reference model.
module tb_mips_fetch_sequencer;
    import mips_fetch_sequencer_pkg::*;

    localparam int QD    = 2;
    localparam int DEPTH = Instruction_Mem_Depth;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: list of queued pcs, fetch pointer, run/halt flags.
    int q[$];
    int fpc;
    bit running, halted, mfault;

    mips_fetch_sequencer_if bus ();

    mips_fetch_sequencer #(.Queue_Depth(QD), .Reset_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int k);
        return 32'hABC0_0000 | 32'(k);
    endfunction

    assign bus.rom_data = rom_word(int'(bus.rom_addr));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("rom_addr", 32'(bus.rom_addr), 32'(fpc));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("fault", 32'(bus.fault), 32'(mfault));
        if (q.size() != 0) begin
            chk("out_pc", 32'(bus.out_pc), 32'(q[0]));
            chk("out_instr", bus.out_instr, rom_word(q[0]));
        end
    endtask

    task automatic model_update(input bit e, input bit r, input bit rv, input int ra);
        int sz;
        bit pop, do_push;
        sz = q.size();
        pop = (sz != 0) && r;
        if (halted) return;
        if (rv) begin
            q.delete();
            if (ra >= DEPTH) begin
                mfault = 1;
                halted = 1;
            end else begin
                fpc = ra;
                if (running) running = e;
            end
            return;
        end
        do_push = running && e && (sz < QD || (sz == QD && pop));
        if (pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(fpc);
            fpc = (fpc + 1) % DEPTH;
        end
        if (!running && e) running = 1;
        else if (running && !e) running = 0;
    endtask

    task automatic step(input bit e, input bit r, input bit rv, input int ra);
        @(negedge clk);
        en                 = e;
        bus.out_ready      = r;
        bus.redirect_valid = rv;
        bus.redirect_addr  = 6'(ra);
        #1;
        check_outputs();
        model_update(e, r, rv, ra);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 0;
        bus.out_ready = 0;
        bus.redirect_valid = 0;
        bus.redirect_addr = '0;
        rst_n = 0;
        #1;
        chk("rst rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_instr", bus.out_instr, 32'd0);
        chk("rst out_pc", 32'(bus.out_pc), 32'd0);
        chk("rst fault", 32'(bus.fault), 32'd0);
        q.delete();
        fpc = 0;
        running = 0;
        halted = 0;
        mfault = 0;
        #1 rst_n = 1;
    endtask

    initial begin
        bus.out_ready = 0;
        bus.redirect_valid = 0;
        bus.redirect_addr = '0;

        // Streaming from reset: first out_valid two cycles after release.
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);

        // Wrap-around past the top of memory.
        step(1, 1, 1, DEPTH - 3);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

        // Backpressure: fill, stall, then drain.
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

        // Redirect to 5 in the cycle pc 3 is popped.
        step(1, 1, 1, 3);
        step(1, 1, 0, 0);
        step(1, 1, 1, 5);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);

        // en low for 3 cycles mid-stream.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);

        // Redirect while IDLE stays IDLE.
        step(0, 1, 0, 0);
        step(1, 1, 1, 20);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);

        // Mid-operation reset.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(7, 0) != 0, $urandom_range(3, 0) != 0,
                 $urandom_range(24, 0) == 0, int'($urandom_range(DEPTH - 1, 0)));

        // Out-of-range redirect: fault, halt, later redirects ignored.
        step(1, 1, 1, DEPTH);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 7);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);

        // Only reset clears fault.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
